// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module : cpu_pkg
// Brief  : Opcodes, sequencer state type and width defaults shared between the
//          opcode decoder and the instruction sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int CNT_W_DEFAULT = 32;
  localparam int OP_W_DEFAULT  = 4;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_LSL = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_SET = 4'b0110;
  localparam logic [3:0] OP_LDR = 4'b0111;
  localparam logic [3:0] OP_STR = 4'b1000;
  localparam logic [3:0] OP_B   = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1010;
  localparam logic [3:0] OP_BGE = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_sequencer.sv
//------------------------------------------------------------------------------
// Module : instr_sequencer
// Brief  : Multi-cycle fetch/decode/execute/memory/writeback sequencer that
//          drives datapath enables and memory handshakes.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int OP_W  = OP_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [OP_W-1:0]  opcode,
  input  logic             flag_z,
  input  logic             flag_n,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_en,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             rf_we,
  output logic             flags_we,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);

  seq_state_t       r_state;
  seq_state_t       w_nextState;
  logic [CNT_W-1:0] r_instrCount;
  logic             w_retire;
  logic [3:0]       w_op;
  logic             w_isMemOp;

  assign w_op        = opcode[3:0];
  assign w_isMemOp   = (w_op == OP_LDR) || (w_op == OP_STR);
  assign instr_count = r_instrCount;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_instrCount <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_retire) begin
        r_instrCount <= r_instrCount + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (run) w_nextState = S_FETCH;
      S_FETCH:  if (imem_ack) w_nextState = S_DECODE;
      S_DECODE: w_nextState = S_EXEC;
      S_EXEC:   if (w_isMemOp) w_nextState = S_MEM;
      S_MEM:    if (dmem_ack && (w_op == OP_LDR)) w_nextState = S_WB;
      S_WB:     w_nextState = S_WB;
      default:  w_nextState = S_IDLE;
    endcase
    // Every retiring state funnels through here so run is only honoured at a boundary.
    if (w_retire) begin
      w_nextState = run ? S_FETCH : S_IDLE;
    end
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = 1'b0;
    rf_we    = 1'b0;
    flags_we = 1'b0;
    w_retire = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_en    = imem_ack;
      end
      S_EXEC: begin
        if (!w_isMemOp) begin
          pc_en    = 1'b1;
          w_retire = 1'b1;
          case (w_op)
            OP_CMP:  flags_we = 1'b1;
            OP_B:    pc_sel   = 1'b1;
            OP_BEQ:  pc_sel   = flag_z;
            OP_BGE:  pc_sel   = ~flag_n;
            // Remaining low opcodes are ALU/SET; 1100-1111 are NOPs.
            default: rf_we    = (w_op < 4'b1000);
          endcase
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (w_op == OP_STR);
        if (dmem_ack && (w_op == OP_STR)) begin
          pc_en    = 1'b1;
          w_retire = 1'b1;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        pc_en    = 1'b1;
        w_retire = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
